// File: rtl/post_normal.sv
// Post-normalization stage of the binary32 adder: effective add/subtract of aligned
// operands, one-bit-per-cycle normalization, round-to-nearest-even and result packing.
module post_normal (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sign_a_i,
    input  logic        sign_b_i,
    input  logic [7:0]  exponent_i,
    input  logic [23:0] mantissa_a_i,
    input  logic [23:0] mantissa_b_i,
    input  logic [2:0]  grs_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        overflow_o,
    output logic        zero_o
);

    typedef enum logic [2:0] {IDLE, ADD, NORM, ROUND, DONE} state_t;

    state_t      state, state_nx;
    logic        sign_a, sign_b, sign, bypass;
    logic [9:0]  exp;
    logic [23:0] mant_a, mant_b;
    logic [2:0]  grs;
    logic [27:0] sum;

    // effective add/subtract on the 27-bit extended mantissas
    logic [26:0] ext_a, ext_b;
    logic [27:0] add_sum;
    logic        add_sign;

    always_comb begin
        ext_a    = {mant_a, 3'b000};
        ext_b    = {mant_b, grs};
        add_sum  = '0;
        add_sign = sign_a;
        if (sign_a == sign_b) begin
            add_sum = {1'b0, ext_a} + {1'b0, ext_b};
        end else if (ext_a >= ext_b) begin
            add_sum = {1'b0, ext_a - ext_b};
        end else begin
            add_sum  = {1'b0, ext_b - ext_a};
            add_sign = sign_b;
        end
    end

    logic        norm_done;
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [23:0] rnd_mant;
    logic [9:0]  rnd_exp;
    logic [7:0]  rnd_field;
    logic        rnd_ovf;

    always_comb begin
        norm_done = sum[26] || (exp == 10'd1);
        rnd_inc   = sum[2] && (sum[1] || sum[0] || sum[3]);
        rnd_sum   = {1'b0, sum[26:3]} + {24'd0, rnd_inc};
        rnd_mant  = rnd_sum[24] ? rnd_sum[24:1] : rnd_sum[23:0];
        rnd_exp   = rnd_sum[24] ? exp + 10'd1 : exp;
        // a clear hidden bit after rounding means the value stayed denormal
        rnd_field = rnd_mant[23] ? rnd_exp[7:0] : 8'd0;
        rnd_ovf   = rnd_exp >= 10'd255;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (valid_i) state_nx = ADD;
            ADD:   state_nx = (add_sum == '0 || bypass) ? DONE : NORM;
            NORM:  if (norm_done) state_nx = ROUND;
            ROUND: state_nx = DONE;
            DONE:  if (ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready_o = (state == IDLE) && !rst_i;
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            sign       <= 1'b0;
            bypass     <= 1'b0;
            exp        <= '0;
            mant_a     <= '0;
            mant_b     <= '0;
            grs        <= '0;
            sum        <= '0;
            result_o   <= '0;
            overflow_o <= 1'b0;
            zero_o     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (valid_i) begin
                    sign_a <= sign_a_i;
                    sign_b <= sign_b_i;
                    mant_a <= mantissa_a_i;
                    mant_b <= mantissa_b_i;
                    grs    <= grs_i;
                    bypass <= (exponent_i == 8'hFF);
                    exp    <= (exponent_i == 8'd0) ? 10'd1 : {2'b00, exponent_i};
                end
                ADD: begin
                    sign <= add_sign;
                    if (add_sum == '0) begin
                        result_o <= '0;
                        zero_o   <= 1'b1;
                    end else if (bypass) begin
                        result_o <= {sign_a, 8'hFF, mant_a[22:0]};
                    end else if (add_sum[27]) begin
                        // carry out: shift right keeping the dropped bit as sticky
                        sum <= {1'b0, add_sum[27:2], add_sum[1] | add_sum[0]};
                        exp <= exp + 10'd1;
                    end else begin
                        sum <= add_sum;
                    end
                end
                NORM: if (!norm_done) begin
                    sum <= {sum[26:0], 1'b0};
                    exp <= exp - 10'd1;
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        result_o   <= {sign, 8'hFF, 23'd0};
                        overflow_o <= 1'b1;
                    end else begin
                        result_o <= {sign, rnd_field, rnd_mant[22:0]};
                    end
                end
                DONE: if (ready_i) begin
                    overflow_o <= 1'b0;
                    zero_o     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_post_normal.sv
// Directed-vector bench for post_normal: results, flags, latency, backpressure and reset abort.
module tb_post_normal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [7:0]  exponent = '0;
    logic [23:0] mant_a = '0, mant_b = '0;
    logic [2:0]  grs = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [31:0] result;
    logic        overflow, zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    post_normal dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(ready),
        .sign_a_i(sign_a), .sign_b_i(sign_b), .exponent_i(exponent),
        .mantissa_a_i(mant_a), .mantissa_b_i(mant_b), .grs_i(grs),
        .valid_o(valid_out), .ready_i(ready_in), .result_o(result),
        .overflow_o(overflow), .zero_o(zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // present one bundle, wait for valid_o; leaves the bench at the first DONE negedge
    task automatic issue(input logic sa, input logic sb, input logic [7:0] e,
                         input logic [23:0] ma, input logic [23:0] mb, input logic [2:0] g,
                         output int lat);
        @(negedge clk);
        sign_a = sa; sign_b = sb; exponent = e; mant_a = ma; mant_b = mb; grs = g;
        valid_in = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            valid_in = 1'b0;
            lat++;
        end while (!valid_out && lat < 100);
    endtask

    task automatic retire(input string tag);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk({tag, "_vclr"}, 32'(valid_out), 32'd0);
        chk({tag, "_ridle"}, 32'(ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic sa, input logic sb, input logic [7:0] e,
                      input logic [23:0] ma, input logic [23:0] mb, input logic [2:0] g,
                      input logic [31:0] res, input logic ovf, input logic zr, input int lat_exp);
        int lat;
        issue(sa, sb, e, ma, mb, g, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_res"}, result, res);
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, "_zero"}, 32'(zero), 32'(zr));
        chk({tag, "_rbusy"}, 32'(ready), 32'd0);
        retire(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(ready), 32'd1);

        op("one_plus_one", 0, 0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 32'h40000000, 0, 0, 4);
        op("one_minus_one", 0, 1, 8'h7F, 24'h800000, 24'h800000, 3'b000, 32'h00000000, 0, 1, 2);
        op("1p5_minus_1p25", 0, 1, 8'h7F, 24'hC00000, 24'hA00000, 3'b000, 32'h3E800000, 0, 0, 6);
        op("b_larger", 0, 1, 8'h7F, 24'h800000, 24'hC00000, 3'b000, 32'hBF000000, 0, 0, 5);
        op("tie_odd", 0, 0, 8'h7F, 24'h800001, 24'h000000, 3'b100, 32'h3F800002, 0, 0, 4);
        op("tie_even", 0, 0, 8'h7F, 24'h800000, 24'h000000, 3'b100, 32'h3F800000, 0, 0, 4);
        op("overflow", 0, 0, 8'hFE, 24'hFFFFFF, 24'hFFFFFF, 3'b000, 32'h7F800000, 1, 0, 4);
        op("bypass_ff", 1, 0, 8'hFF, 24'h800000, 24'h400000, 3'b000, 32'hFF800000, 0, 0, 2);
        op("denorm_add", 0, 0, 8'h00, 24'h000001, 24'h000001, 3'b000, 32'h00000002, 0, 0, 4);
        op("denorm_promote", 0, 0, 8'h00, 24'h400000, 24'h400000, 3'b000, 32'h00800000, 0, 0, 4);

        // backpressure: result held while ready_i is low
        issue(0, 0, 8'h7F, 24'h800000, 24'h800000, 3'b000, lat);
        held = result;
        chk("bp_res0", held, 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_res", result, 32'h40000000);
            chk("bp_ready", 32'(ready), 32'd0);
        end
        retire("bp");

        // reset during NORM aborts the operation
        @(negedge clk);
        sign_a = 0; sign_b = 1; exponent = 8'h7F; mant_a = 24'hC00000; mant_b = 24'hA00000; grs = 0;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_ready_in_rst", 32'(ready), 32'd0);
        rst = 1'b0;
        #1 chk("abort_ready_after", 32'(ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(valid_out), 32'd0);
        end

        op("after_abort", 0, 0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 32'h40000000, 0, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
